// File: rtl/wb_write_ctrl.sv
// Register-file writeback controller: merges the ALU and the buffered LSU/MUL completions onto one write port.
// Optional macro WB_X0_FILTER_EN suppresses the write enable for rd=0 winners.
module wb_write_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ALU_VALID,
  input  logic [ADDR_WIDTH-1:0]       ALU_RD,
  input  logic [DATA_WIDTH-1:0]       ALU_DATA,
  input  logic                        LSU_VALID,
  output logic                        LSU_READY,
  input  logic [ADDR_WIDTH-1:0]       LSU_RD,
  input  logic [DATA_WIDTH-1:0]       LSU_DATA,
  input  logic                        ISSUE_VALID,
  input  logic [ADDR_WIDTH-1:0]       ISSUE_RD,
  output logic [(1<<ADDR_WIDTH)-1:0]  BUSY,
  output logic                        ALU_STALL,
  output logic                        WEN,
  output logic [ADDR_WIDTH-1:0]       RD_SEL,
  output logic [DATA_WIDTH-1:0]       WB_DATA
);

  localparam int unsigned NREG  = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic                  stall_q, stall_d;
  logic [NREG-1:0]       busy_q, busy_d;
  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  push_c, pop_c, fifo_empty_c, win_c, wr_en_c;
  logic [ADDR_WIDTH-1:0] head_rd_c, win_rd_c;
  logic [DATA_WIDTH-1:0] head_data_c, win_data_c;

  assign fifo_empty_c = (count_q == '0);
  assign LSU_READY    = (count_q < CNT_W'(FIFO_DEPTH)) && !RESET;
  assign push_c       = LSU_VALID && LSU_READY;
  assign pop_c        = !ALU_VALID && !fifo_empty_c;
  assign head_rd_c    = mem_q[rptr_q][DATA_WIDTH +: ADDR_WIDTH];
  assign head_data_c  = mem_q[rptr_q][DATA_WIDTH-1:0];

  // ALU has absolute priority; the FIFO head only drains on idle ALU cycles.
  assign win_c      = ALU_VALID || pop_c;
  assign win_rd_c   = ALU_VALID ? ALU_RD   : head_rd_c;
  assign win_data_c = ALU_VALID ? ALU_DATA : head_data_c;

`ifdef WB_X0_FILTER_EN
  assign wr_en_c = win_c && (win_rd_c != '0);
`else
  assign wr_en_c = win_c;
`endif

  // Completion FIFO: pointers wrap naturally since depth is a power of two.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_c) begin
      mem_d[wptr_q] = {LSU_RD, LSU_DATA};
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  // Write port; address and data hold whenever nothing is written.
  always_comb begin
    wen_d  = wr_en_c;
    rd_d   = rd_q;
    data_d = data_q;
    if (wr_en_c) begin
      rd_d   = win_rd_c;
      data_d = win_data_c;
    end
  end

  // Starvation tracking: a non-empty FIFO without a pop means the ALU won.
  always_comb begin
    starve_d = starve_q;
    stall_d  = stall_q;
    if (pop_c) begin
      starve_d = '0;
      stall_d  = 1'b0;
    end else if (fifo_empty_c) begin
      starve_d = '0;
    end else begin
      if (starve_q != STV_W'(STARVE_LIMIT)) begin
        starve_d = starve_q + STV_W'(1);
      end
      if (starve_d == STV_W'(STARVE_LIMIT)) begin
        stall_d = 1'b1;
      end
    end
  end

  // Scoreboard: the set is applied after the clear so a same-cycle reissue wins.
  always_comb begin
    busy_d = busy_q;
    if (pop_c) begin
      busy_d[head_rd_c] = 1'b0;
    end
    if (ISSUE_VALID && (ISSUE_RD != '0)) begin
      busy_d[ISSUE_RD] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mem_q    <= '{default: '0};
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
      wen_q    <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
      wen_q    <= wen_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  assign BUSY      = busy_q;
  assign ALU_STALL = stall_q;
  assign WEN       = wen_q;
  assign RD_SEL    = rd_q;
  assign WB_DATA   = data_q;

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Bench for wb_write_ctrl: directed vector table followed by randomized traffic against a queue-based model.
module tb_wb_write_ctrl;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 3;

  logic          CLK = 1'b0;
  logic          RESET, ALU_VALID, LSU_VALID, ISSUE_VALID;
  logic [AW-1:0] ALU_RD, LSU_RD, ISSUE_RD;
  logic [DW-1:0] ALU_DATA, LSU_DATA;
  logic          LSU_READY, ALU_STALL, WEN;
  logic [31:0]   BUSY;
  logic [AW-1:0] RD_SEL;
  logic [DW-1:0] WB_DATA;

  wb_write_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
    .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
    .BUSY(BUSY), .ALU_STALL(ALU_STALL),
    .WEN(WEN), .RD_SEL(RD_SEL), .WB_DATA(WB_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iv;
    logic [4:0]  ird;
    logic        e_rdy, e_wen;
    logic [4:0]  e_rd;
    logic [31:0] e_dat, e_busy;
    logic        e_stall;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_busy;
  int unsigned m_starve;
  logic        m_stall, m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic iv, input logic [4:0] ird,
                      input logic e_rdy, input logic e_wen, input logic [4:0] e_rd,
                      input logic [31:0] e_dat, input logic [31:0] e_busy, input logic e_stall);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.iv = iv; v.ird = ird;
    v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_rd = e_rd; v.e_dat = e_dat;
    v.e_busy = e_busy; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic iv, input logic [4:0] ird);
    RESET = rst; ALU_VALID = av; ALU_RD = ard; ALU_DATA = adat;
    LSU_VALID = lv; LSU_RD = lrd; LSU_DATA = ldat;
    ISSUE_VALID = iv; ISSUE_RD = ird;
  endtask

  // One clock edge of the writeback behaviour, in terms of a plain queue and counters.
  task automatic model_step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                            input logic iv, input logic [4:0] ird);
    ent_t        e;
    bit          win, rdy;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    int unsigned occ;
    if (rst) begin
      mq.delete();
      m_busy = '0; m_starve = 0; m_stall = 1'b0;
      m_wen = 1'b0; m_rd = '0; m_data = '0;
      return;
    end
    occ  = mq.size();
    rdy  = occ < DEPTH;
    win  = 1'b0;
    wrd  = '0;
    wdat = '0;
    if (av) begin
      win = 1'b1; wrd = ard; wdat = adat;
      if (occ > 0) begin
        if (m_starve < LIMIT) m_starve++;
        if (m_starve == LIMIT) m_stall = 1'b1;
      end else begin
        m_starve = 0;
      end
    end else if (occ > 0) begin
      e = mq.pop_front();
      win = 1'b1; wrd = e.rd; wdat = e.data;
      m_busy[e.rd] = 1'b0;
      m_starve = 0;
      m_stall  = 1'b0;
    end
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
    if (lv && rdy) begin
      e.rd = lrd; e.data = ldat;
      mq.push_back(e);
    end
`ifdef WB_X0_FILTER_EN
    m_wen = win && (wrd != 5'd0);
`else
    m_wen = win;
`endif
    if (m_wen) begin
      m_rd = wrd; m_data = wdat;
    end
  endtask

  initial begin
    logic        r_rst, r_av, r_lv, r_iv;
    logic [4:0]  r_ard, r_lrd, r_ird;
    logic [31:0] r_adat, r_ldat;

    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);

    //   rst av ard   adat         lv lrd   ldat         iv ird   rdy wen rd    dat          busy          stall
    addv(1, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 0, 0, 5'd0, 32'h0,       32'h0,        0);
    addv(1, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 0, 0, 5'd0, 32'h0,       32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 5'd0, 32'h0,       32'h0,        0);
    addv(0, 1, 5'd5, 32'h41,      0, 5'd0, 32'h0,       0, 5'd0, 1, 1, 5'd5, 32'h41,      32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 5'd5, 32'h41,      32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       1, 5'd7, 1, 0, 5'd5, 32'h41,      32'h80,       0);
    addv(0, 0, 5'd0, 32'h0,       1, 5'd7, 32'hDEAD,    0, 5'd0, 1, 0, 5'd5, 32'h41,      32'h80,       0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 1, 5'd7, 32'hDEAD,    32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 5'd7, 32'hDEAD,    32'h0,        0);
    // ALU held high while four entries are pushed; stall rises on the third win over a non-empty FIFO
    addv(0, 1, 5'd10, 32'hA0,     1, 5'd1, 32'h101,     0, 5'd0, 1, 1, 5'd10, 32'hA0,     32'h0,        0);
    addv(0, 1, 5'd10, 32'hA1,     1, 5'd2, 32'h102,     0, 5'd0, 1, 1, 5'd10, 32'hA1,     32'h0,        0);
    addv(0, 1, 5'd10, 32'hA2,     1, 5'd3, 32'h103,     0, 5'd0, 1, 1, 5'd10, 32'hA2,     32'h0,        0);
    addv(0, 1, 5'd10, 32'hA3,     1, 5'd4, 32'h104,     0, 5'd0, 1, 1, 5'd10, 32'hA3,     32'h0,        1);
    addv(0, 1, 5'd10, 32'hA4,     1, 5'd5, 32'h105,     0, 5'd0, 0, 1, 5'd10, 32'hA4,     32'h0,        1);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 0, 1, 5'd1, 32'h101,     32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 1, 5'd2, 32'h102,     32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       1, 5'd9, 1, 1, 5'd3, 32'h103,     32'h200,      0);
    addv(0, 0, 5'd0, 32'h0,       1, 5'd9, 32'h909,     0, 5'd0, 1, 1, 5'd4, 32'h104,     32'h200,      0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       1, 5'd9, 1, 1, 5'd9, 32'h909,     32'h200,      0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 5'd9, 32'h909,     32'h200,      0);
`ifdef WB_X0_FILTER_EN
    addv(0, 1, 5'd0, 32'd23,      0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 5'd9, 32'h909,     32'h200,      0);
`else
    addv(0, 1, 5'd0, 32'd23,      0, 5'd0, 32'h0,       0, 5'd0, 1, 1, 5'd0, 32'd23,      32'h200,      0);
`endif
    addv(0, 1, 5'd12, 32'hC0,     0, 5'd0, 32'h0,       0, 5'd0, 1, 1, 5'd12, 32'hC0,     32'h200,      0);
    // Park three entries behind a busy ALU, then reset them away
    addv(0, 1, 5'd12, 32'hC1,     1, 5'd11, 32'hB1,     0, 5'd0, 1, 1, 5'd12, 32'hC1,     32'h200,      0);
    addv(0, 1, 5'd12, 32'hC2,     1, 5'd13, 32'hB2,     0, 5'd0, 1, 1, 5'd12, 32'hC2,     32'h200,      0);
    addv(0, 1, 5'd12, 32'hC3,     1, 5'd14, 32'hB3,     0, 5'd0, 1, 1, 5'd12, 32'hC3,     32'h200,      0);
    addv(1, 0, 5'd0, 32'h0,       1, 5'd15, 32'hB4,     0, 5'd0, 0, 0, 5'd0, 32'h0,       32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 5'd0, 32'h0,       32'h0,        0);
    addv(0, 0, 5'd0, 32'h0,       0, 5'd0, 32'h0,       0, 5'd0, 1, 0, 5'd0, 32'h0,       32'h0,        0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].adat,
            vecs[i].lv, vecs[i].lrd, vecs[i].ldat, vecs[i].iv, vecs[i].ird);
      #1;
      chk($sformatf("v%0d_lsu_ready", i), 64'(LSU_READY), 64'(vecs[i].e_rdy));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_wen", i),       64'(WEN),       64'(vecs[i].e_wen));
      chk($sformatf("v%0d_rd_sel", i),    64'(RD_SEL),    64'(vecs[i].e_rd));
      chk($sformatf("v%0d_wb_data", i),   64'(WB_DATA),   64'(vecs[i].e_dat));
      chk($sformatf("v%0d_busy", i),      64'(BUSY),      64'(vecs[i].e_busy));
      chk($sformatf("v%0d_alu_stall", i), 64'(ALU_STALL), 64'(vecs[i].e_stall));
    end

    // Randomized traffic; the ALU mostly honours the stall request
    for (int c = 0; c < 3000; c++) begin
      r_rst  = (c == 0) || ($urandom_range(0, 299) == 0);
      r_av   = m_stall ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      r_ard  = 5'($urandom_range(0, 7));
      r_adat = $urandom;
      r_lv   = ($urandom_range(0, 2) != 0);
      r_lrd  = 5'($urandom_range(0, 7));
      r_ldat = $urandom;
      r_iv   = ($urandom_range(0, 3) == 0);
      r_ird  = 5'($urandom_range(0, 7));
      drive(r_rst, r_av, r_ard, r_adat, r_lv, r_lrd, r_ldat, r_iv, r_ird);
      #1;
      chk($sformatf("r%0d_lsu_ready", c), 64'(LSU_READY),
          64'((!r_rst) && (mq.size() < DEPTH)));
      @(posedge CLK);
      model_step(r_rst, r_av, r_ard, r_adat, r_lv, r_lrd, r_ldat, r_iv, r_ird);
      #1;
      chk($sformatf("r%0d_wen", c),       64'(WEN),       64'(m_wen));
      chk($sformatf("r%0d_rd_sel", c),    64'(RD_SEL),    64'(m_rd));
      chk($sformatf("r%0d_wb_data", c),   64'(WB_DATA),   64'(m_data));
      chk($sformatf("r%0d_busy", c),      64'(BUSY),      64'(m_busy));
      chk($sformatf("r%0d_alu_stall", c), 64'(ALU_STALL), 64'(m_stall));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
